// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle of the seg_scan_ctrl: scan enable, load strobe and data in,
// digit nibble, anode enables and status pulses out.
interface seg_scan_ctrl_if #(
  parameter int unsigned NDIG = 4
);
  logic              en;
  logic              load;
  logic [4*NDIG-1:0] data;
  logic [3:0]        digit;
  logic [NDIG-1:0]   an;
  logic              ack;
  logic              frame;

  modport master (output en, load, data, input digit, an, ack, frame);
  modport slave  (input en, load, data, output digit, an, ack, frame);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous double buffering.
// Optional leading-zero blanking is built when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl #(
  parameter int unsigned NDIG  = 4,
  parameter int unsigned DIV   = 50000,
  parameter int unsigned GUARD = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned IW = $clog2(NDIG);
  localparam int unsigned WW = 4 * NDIG;

  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_idx;
  logic [WW-1:0]   r_act;
  logic [WW-1:0]   r_pnd;
  logic            r_pflag;
  logic [NDIG-1:0] r_an;
  logic [3:0]      r_digit;
  logic            r_ack;
  logic            r_frame;

  logic            w_wrap;
  logic            w_bound;
  logic            w_commit;
  logic            w_on;
  logic [CW-1:0]   w_cnt_n;
  logic [IW-1:0]   w_idx_n;
  logic [WW-1:0]   w_act_n;
  logic [WW-1:0]   w_pnd_n;
  logic            w_pflag_n;
  logic [NDIG-1:0] w_blank;
  logic [NDIG-1:0] w_an_n;
  logic [3:0]      w_digit_n;

  // Next-state of the scan position and the double buffer
  always_comb begin
    w_wrap  = bus.en && (r_cnt == CW'(DIV - 1));
    w_bound = w_wrap && (r_idx == IW'(NDIG - 1));

    w_cnt_n = r_cnt;
    if (bus.en) w_cnt_n = w_wrap ? '0 : r_cnt + CW'(1);
    w_idx_n = r_idx;
    if (w_wrap) w_idx_n = w_bound ? '0 : r_idx + IW'(1);

    // A load on the boundary cycle bypasses pnd so the newest word wins
    w_commit = w_bound && (r_pflag || bus.load);
    w_act_n  = r_act;
    if (w_commit) w_act_n = bus.load ? bus.data : r_pnd;
    w_pnd_n   = bus.load ? bus.data : r_pnd;
    w_pflag_n = w_commit ? 1'b0 : (bus.load ? 1'b1 : r_pflag);
  end

`ifdef SEG_SCAN_LZB_EN
  logic w_zero;

  // Digit i blanks when its nibble and every nibble above it are zero
  always_comb begin
    w_blank = '0;
    w_zero  = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      w_zero     = w_zero && (w_act_n[4*i +: 4] == 4'd0);
      w_blank[i] = w_zero;
    end
  end
`else
  assign w_blank = '0;
`endif

  // Outputs are derived from next-state values so they line up with cnt/idx
  always_comb begin
    w_on      = bus.en && (w_cnt_n >= CW'(GUARD));
    w_an_n    = '1;
    w_digit_n = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (w_idx_n == IW'(i)) begin
        w_digit_n = w_act_n[4*i +: 4];
        if (w_on && !w_blank[i]) w_an_n[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_act   <= '0;
      r_pnd   <= '0;
      r_pflag <= 1'b0;
      r_an    <= '1;
      r_digit <= 4'd0;
      r_ack   <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_act   <= w_act_n;
      r_pnd   <= w_pnd_n;
      r_pflag <= w_pflag_n;
      r_an    <= w_an_n;
      r_digit <= w_digit_n;
      r_ack   <= w_commit;
      r_frame <= w_bound;
    end
  end

  assign bus.an    = r_an;
  assign bus.digit = r_digit;
  assign bus.ack   = r_ack;
  assign bus.frame = r_frame;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized and directed bench for seg_scan_ctrl against a frame-position reference model.
module tb_seg_scan_ctrl;

  localparam int unsigned NDIG  = 4;
  localparam int unsigned DIV   = 8;
  localparam int unsigned GUARD = 2;
  localparam int unsigned FLEN  = NDIG * DIV;

  logic clk;
  logic rst_n;

  seg_scan_ctrl_if #(.NDIG(NDIG)) bus ();

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .GUARD(GUARD)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_ack    = 0;
  int n_frame  = 0;

  // Reference: position in the frame, the shown word, and a pending word
  int          m_pos = 0;
  logic [15:0] m_act = '0;
  logic [15:0] m_pnd = '0;
  bit          m_pv  = 1'b0;
  logic        e_ack;
  logic        e_frame;
  logic [3:0]  e_digit;
  logic [3:0]  e_an;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h (pos %0d)", tag, obs, expv, m_pos);
    end
  endtask

  task automatic step(input logic rst_i, input logic en_i, input logic load_i,
                      input logic [15:0] data_i);
    bit bnd;
    int idx;
    bit lit;
    rst_n    = rst_i;
    bus.en   = en_i;
    bus.load = load_i;
    bus.data = data_i;
    @(posedge clk);
    #1;
    if (!rst_i) begin
      m_pos = 0; m_act = '0; m_pnd = '0; m_pv = 1'b0;
      e_ack = 1'b0; e_frame = 1'b0;
    end else begin
      bnd     = en_i && (m_pos == FLEN - 1);
      e_frame = bnd;
      e_ack   = bnd && (m_pv || load_i);
      if (e_ack) begin
        m_act = load_i ? data_i : m_pnd;
        m_pv  = 1'b0;
      end else if (load_i) begin
        m_pnd = data_i;
        m_pv  = 1'b1;
      end
      if (en_i) m_pos = (m_pos + 1) % FLEN;
    end
    idx     = m_pos / DIV;
    e_digit = 4'((m_act >> (4 * idx)) & 16'hF);
    e_an    = 4'hF;
    if (rst_i && en_i && (m_pos % DIV) >= GUARD) begin
      lit = 1'b1;
`ifdef SEG_SCAN_LZB_EN
      if (idx > 0 && (m_act >> (4 * idx)) == 16'h0) lit = 1'b0;
`endif
      if (lit) e_an[idx] = 1'b0;
    end
    if (bus.ack)   n_ack++;
    if (bus.frame) n_frame++;
    chk("an",    32'(bus.an),    32'(e_an));
    chk("digit", 32'(bus.digit), 32'(e_digit));
    chk("ack",   32'(bus.ack),   32'(e_ack));
    chk("frame", 32'(bus.frame), 32'(e_frame));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b1, 1'b0, 16'h0);
  endtask

  // Advance with EN=1 until the model sits at frame position p (bounded)
  task automatic run_to(input int p);
    int budget = 2 * FLEN;
    while (m_pos != p && budget > 0) begin
      step(1'b1, 1'b1, 1'b0, 16'h0);
      budget--;
    end
    chk("reach_pos", 32'(m_pos), 32'(p));
  endtask

  int a0;
  int f0;

  initial begin
    rst_n = 1'b0; bus.en = 1'b0; bus.load = 1'b0; bus.data = '0;

    // Reset and plain scanning
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("rst_an", 32'(bus.an), 32'h0000_000F);
    chk("rst_digit", 32'(bus.digit), 32'h0);
    f0 = n_frame;
    run(2);
    chk("first_on", 32'(bus.an), 32'h0000_000E);
    run(FLEN * 2 - 2);
    chk("frames_2", 32'(n_frame - f0), 32'd2);

    // Buffered load mid-frame
    run_to(9);
    a0 = n_ack;
    step(1'b1, 1'b1, 1'b1, 16'h1234);
    run_to(31);
    chk("no_early_ack", 32'(n_ack - a0), 32'd0);
    chk("digit_old", 32'(bus.digit), 32'h0);
    run(1);
    chk("ack_once", 32'(n_ack - a0), 32'd1);
    for (int d = 0; d < NDIG; d++) begin
      if (d > 0) run(DIV);
      chk("new_digit", 32'(bus.digit), 32'(4 - d));
    end

    // Collision: load on the boundary cycle wins over the pending word
    run_to(4);
    step(1'b1, 1'b1, 1'b1, 16'hAAAA);
    run_to(31);
    a0 = n_ack;
    step(1'b1, 1'b1, 1'b1, 16'h5678);
    chk("coll_digit0", 32'(bus.digit), 32'h8);
    run(FLEN + 2);
    chk("coll_one_ack", 32'(n_ack - a0), 32'd1);

    // EN gating at idx=2, cnt=5
    run_to(2 * DIV + 5);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("gate_an", 32'(bus.an), 32'h0000_000F);
    chk("gate_pos", 32'(m_pos), 32'(2 * DIV + 5));
    run(2);
    chk("resume_an", 32'(bus.an), 32'h0000_000B);
    run(1);

    // Reset with data pending
    step(1'b1, 1'b1, 1'b1, 16'h9999);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    a0 = n_ack;
    run(FLEN * 2);
    chk("rst_no_ack", 32'(n_ack - a0), 32'd0);

    // Leading-zero patterns
    step(1'b1, 1'b1, 1'b1, 16'h0050);
    run(FLEN * 2);
    step(1'b1, 1'b1, 1'b1, 16'h0000);
    run(FLEN * 2);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      logic        r_r, e_r, l_r;
      logic [15:0] d_r;
      r_r = ($urandom_range(0, 199) != 0);
      e_r = ($urandom_range(0, 9) != 0);
      l_r = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       d_r = 16'($urandom_range(0, 15)) << (4 * $urandom_range(0, 3));
        1:       d_r = 16'h0;
        default: d_r = 16'($urandom);
      endcase
      step(r_r, e_r, l_r, d_r);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller that shares one 4-bit-to-7-segment decoder (active-low segment outputs) across NDIG common-anode digits. Holds a double-buffered display word, presents one nibble at a time on DIGIT to the decoder, drives the active-low anode enables, and inserts a ghosting guard interval at every digit change. New display data is committed only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- NDIG, 4: number of digits scanned, range 2..8.
- DIV, 50000: clock cycles per digit slot, at least GUARD+2.
- GUARD, 16: cycles at the start of each slot with all anodes off, at least 1.
- CLK  in  1  system clock; all logic is on the rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- EN  in  1  scan enable; 0 freezes the scan and blanks the display.
- DATA  in  4*NDIG  display word; nibble i (DATA[4i+3:4i]) is digit i, and digit 0 is rightmost.
- LOAD  in  1  single-cycle strobe that samples DATA into the pending buffer.
- DIGIT  out  4  nibble for the current digit, fed to the decoder.
- AN  out  NDIG  anode enables, active-low, at most one bit low at a time.
- ACK  out  1  one-cycle pulse when pending data becomes active.
- FRAME  out  1  one-cycle pulse at every frame wrap.

## Operation
- Registers:
  - cnt, a slot counter running 0..DIV-1.
  - idx, the digit index running 0..NDIG-1.
  - act, the active word (4*NDIG bits).
  - pnd, the pending word (4*NDIG bits).
  - pflag, a flag that marks pnd as valid.
- State per slot, decoded from cnt:
  - GUARD state (cnt < GUARD): AN is all 1s.
  - ON state (cnt >= GUARD): AN[idx] is 0 and all other bits are 1.
- DIGIT is always act[4*idx+3:4*idx], including during GUARD.
- With EN=1:
  - cnt increments every cycle.
  - At cnt==DIV-1, cnt wraps to 0 and idx advances.
  - idx wraps from NDIG-1 to 0; this is the frame boundary.
- With EN=0:
  - cnt, idx, pnd/pflag commit and FRAME all hold.
  - AN is forced to all 1s.
  - LOAD is still accepted into pnd.
- LOAD=1 (any cycle, any EN):
  - pnd <= DATA and pflag <= 1.
  - A later LOAD before commit overwrites pnd; the last one wins.
- Commit occurs at the frame boundary (EN=1, cnt==DIV-1, idx==NDIG-1):
  - If pflag=1: act <= pnd, pflag <= 0, and ACK pulses on the next cycle.
  - If LOAD=1 in the same cycle: act <= DATA directly (newest wins), pflag <= 0, and ACK pulses.
- FRAME pulses on the cycle after the boundary, whether or not a commit happens.
- Reset (RST_N=0 at an edge) returns everything to its reset state from any state, mid-slot or mid-frame, and discards pending data. Reset values:
  - cnt=0, idx=0, act=0, pnd=0, pflag=0.
  - AN all 1s, DIGIT=0, ACK=0, FRAME=0.

## Timing
- All outputs are registered and computed from next-state values, so they align with cnt/idx. When the register holds cnt=c and idx=i, AN and DIGIT show the values for (c,i) in that same cycle.
- First cycle after reset release with EN=1:
  - cnt=0, so the slot starts in GUARD and AN is all 1s.
  - AN[0] first goes low GUARD cycles later.
- Frame period is NDIG*DIV cycles.
- ACK/FRAME go high one cycle after the boundary edge, i.e. coincident with the cycle where idx=0 and cnt=0, and last exactly one cycle.
- Commit latency depends on when LOAD arrives:
  - Worst case, LOAD just after a boundary: NDIG*DIV cycles to ACK.
  - Best case, LOAD on the boundary cycle: 1 cycle to ACK.
- EN toggling mid-slot: AN goes to all 1s in the same cycle that EN=0 is registered. On resume, counting continues from the held cnt/idx; the slot is not restarted.

## Configuration
- Macro: SEG_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - During ON, digit i (for i>0) is blanked (AN stays all 1s) when act nibble i and every nibble above it are 0.
  - Digit 0 is never blanked.
  - DIGIT, cnt, idx and slot timing are unchanged.
- Undefined: every digit is lit in its ON window regardless of value, and the blanking logic is not synthesized.

## Test plan
All scenarios use NDIG=4, DIV=8, GUARD=2.
- Reset/scan: hold RST_N=0 for 3 cycles, then EN=1 -> AN=4'b1111 and DIGIT=0 at release; AN=4'b1110 at cnt=2..7; AN=4'b1101 from cycle 10; FRAME pulses every 32 cycles.
- Buffered load: LOAD with DATA=16'h1234 mid-frame -> DIGIT is unchanged until the boundary; ACK pulses once at the next idx=0/cnt=0; DIGIT then reads 4,3,2,1 for idx 0..3.
- Collision: LOAD 16'hAAAA, then LOAD 16'h5678 on the boundary cycle -> act=16'h5678, exactly one ACK, pflag=0.
- EN gating: EN=0 at idx=2, cnt=5 for 10 cycles -> AN=4'b1111 with cnt/idx frozen; after EN=1, AN[2]=0 for 2 more cycles.
- Reset mid-operation: pending LOAD of 16'h9999, then RST_N=0 for one edge -> act=0, no ACK ever appears, AN=4'b1111.
- SEG_SCAN_LZB_EN defined, act=16'h0050 -> digits 0 and 1 lit, digits 2 and 3 never driven low; act=16'h0000 -> only digit 0 lit, showing 0.
